ram_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the 256x16 single-port data RAM.
- Master 0 is the CPU load/store unit; master 1 is the DMA/loader.
- Per master: one request/acknowledge transaction at a time.
- Drives the RAM address, write data, write and chip-select lines, and registers the RAM's combinational read data back to the granted master.

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/ram_arbiter_if.sv | 43 ++++
 rtl/ram_arbiter_arb_rr2.sv | 22 ++
 rtl/ram_arbiter.sv | 103 ++++++++++
 tb/tb_ram_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master data RAM arbiter: default bus widths
// and the sequencer state encoding.
package ram_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of both masters' request buses plus the RAM-side port of the arbiter.
// The slave modport is the arbiter's view; master is the requesters'/RAM's view.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;

    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_write;
    logic              ram_cs;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_ack, m1_ack, rdata,
        output ram_addr, ram_din, ram_write, ram_cs,
        input  ram_dout
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_ack, m1_ack, rdata,
        input  ram_addr, ram_din, ram_write, ram_cs,
        output ram_dout
    );

endinterface

// File: rtl/ram_arbiter_arb_rr2.sv
// Combinational two-way picker, reusable by any shared-resource arbiter.
// On a tie it either favours requester 0 or the one that did not win last time.
module arb_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic fixed_prio,
    output logic any,
    output logic winner
);

    always_comb begin
        any    = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = fixed_prio ? 1'b0 : ~last_grant;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter and three-state sequencer (IDLE -> ACCESS -> DONE) between the CPU
// load/store unit (master 0) and the DMA/loader (master 1) for the data RAM.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic          clk,
    input logic          rst,
    ram_arbiter_if.slave bus
);

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              any;
    logic              winner;
    logic              access;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    arb_rr2 u_pick (
        .req0       (bus.m0_req),
        .req1       (bus.m1_req),
        .last_grant (last_q),
        .fixed_prio (FIXED_PRIO),
        .any        (any),
        .winner     (winner)
    );

    // Address/data come from the live inputs of whichever master was latched at grant.
    assign access    = (state_q == ST_ACCESS);
    assign sel_we    = sel_q ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = sel_q ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = sel_q ? bus.m1_wdata : bus.m0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rdata_q <= rdata_d;
        end
    end

    // DONE ignores requests on purpose: the just-acked master may still hold req.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    sel_d   = winner;
                    last_d  = winner;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!sel_we) begin
                    rdata_d = bus.ram_dout;
                end
                ack0_d  = ~sel_q;
                ack1_d  = sel_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ram_cs    = access;
    assign bus.ram_write = access & sel_we;
    assign bus.ram_addr  = access ? sel_addr  : '0;
    assign bus.ram_din   = access ? sel_wdata : '0;
    assign bus.m0_ack    = ack0_q;
    assign bus.m1_ack    = ack1_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical master traffic,
// each against its own RAM model, and compares them to a transaction-level model.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus_rr ();
    ram_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus_fp ();

    ram_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRIO(1'b0)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    ram_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRIO(1'b1)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus_fp)
    );

    logic        m_req   [2] = '{1'b0, 1'b0};
    logic        m_we    [2] = '{1'b0, 1'b0};
    logic [7:0]  m_addr  [2] = '{8'h0, 8'h0};
    logic [15:0] m_wdata [2] = '{16'h0, 16'h0};

    assign bus_rr.m0_req = m_req[0];   assign bus_fp.m0_req = m_req[0];
    assign bus_rr.m0_we  = m_we[0];    assign bus_fp.m0_we  = m_we[0];
    assign bus_rr.m0_addr = m_addr[0]; assign bus_fp.m0_addr = m_addr[0];
    assign bus_rr.m0_wdata = m_wdata[0]; assign bus_fp.m0_wdata = m_wdata[0];
    assign bus_rr.m1_req = m_req[1];   assign bus_fp.m1_req = m_req[1];
    assign bus_rr.m1_we  = m_we[1];    assign bus_fp.m1_we  = m_we[1];
    assign bus_rr.m1_addr = m_addr[1]; assign bus_fp.m1_addr = m_addr[1];
    assign bus_rr.m1_wdata = m_wdata[1]; assign bus_fp.m1_wdata = m_wdata[1];

    // The 256x16 RAMs: synchronous write, combinational read, floating when deselected.
    logic [15:0] ram_rr [256] = '{default: 16'h0};
    logic [15:0] ram_fp [256] = '{default: 16'h0};

    always @(posedge clk) begin
        if (bus_rr.ram_cs && bus_rr.ram_write) ram_rr[bus_rr.ram_addr] <= bus_rr.ram_din;
        if (bus_fp.ram_cs && bus_fp.ram_write) ram_fp[bus_fp.ram_addr] <= bus_fp.ram_din;
    end

    assign bus_rr.ram_dout = bus_rr.ram_cs ? ram_rr[bus_rr.ram_addr] : 16'hzzzz;
    assign bus_fp.ram_dout = bus_fp.ram_cs ? ram_fp[bus_fp.ram_addr] : 16'hzzzz;

    logic [43:0] snap [2];
    assign snap[0] = {bus_rr.m0_ack, bus_rr.m1_ack, bus_rr.ram_cs, bus_rr.ram_write,
                      bus_rr.ram_addr, bus_rr.ram_din, bus_rr.rdata};
    assign snap[1] = {bus_fp.m0_ack, bus_fp.m1_ack, bus_fp.ram_cs, bus_fp.ram_write,
                      bus_fp.ram_addr, bus_fp.ram_din, bus_fp.rdata};

    // Reference model: memory image, last data returned per arbiter, round-robin history.
    logic [15:0] ref_mem [256] = '{default: 16'h0};
    logic [15:0] exp_rdata [2];
    int          last_rr;
    bit          in_done;
    string       dut_name [2] = '{"rr", "fp"};

    int checks   = 0;
    int failures = 0;

    function automatic logic [43:0] pack(input logic a0, input logic a1, input logic cs,
                                         input logic wr, input logic [7:0] ad,
                                         input logic [15:0] din, input logic [15:0] rd);
        return {a0, a1, cs, wr, ad, din, rd};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Invariants that must hold in every cycle of both arbiters.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                check({dut_name[k], " two_acks"}, 64'(snap[k][43] & snap[k][42]), 64'd0);
                check({dut_name[k], " write_without_cs"}, 64'(snap[k][40] & ~snap[k][41]), 64'd0);
                if (!snap[k][41]) check({dut_name[k], " idle_bus_nonzero"}, 64'(snap[k][39:16]), 64'd0);
            end
        end
    end

    task automatic model_reset();
        last_rr      = 1;
        exp_rdata[0] = 16'h0;
        exp_rdata[1] = 16'h0;
        in_done      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                check({dut_name[k], " idle"}, 64'(snap[k]), 64'(pack(0, 0, 0, 0, 8'h0, 16'h0, exp_rdata[k])));
        end
        if (n > 0) in_done = 1'b0;
    endtask

    // One uncontended transaction; returns at the negedge of the ack cycle with req dropped.
    task automatic txn(input int m, input logic we, input logic [7:0] addr, input logic [15:0] wdata);
        int lat;
        int exp_lat;
        exp_lat    = in_done ? 2 : 1;
        m_req[m]   = 1'b1;
        m_we[m]    = we;
        m_addr[m]  = addr;
        m_wdata[m] = wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_rr.ram_cs && lat < 4);
        check("grant_latency", 64'(lat), 64'(exp_lat));
        for (int k = 0; k < 2; k++)
            check({dut_name[k], " access"}, 64'(snap[k]), 64'(pack(0, 0, 1, we, addr, wdata, exp_rdata[k])));
        @(negedge clk);
        if (we) begin
            ref_mem[addr] = wdata;
        end else begin
            exp_rdata[0] = ref_mem[addr];
            exp_rdata[1] = ref_mem[addr];
        end
        last_rr = m;
        for (int k = 0; k < 2; k++)
            check({dut_name[k], " done"}, 64'(snap[k]),
                  64'(pack(m == 0, m == 1, 0, 0, 8'h0, 16'h0, exp_rdata[k])));
        m_req[m] = 1'b0;
        in_done  = 1'b1;
    endtask

    // Both masters reading continuously; the round-robin unit must alternate, the
    // fixed-priority unit must serve master 0 only.  Then master 0 backs off.
    task automatic contention(input int rounds);
        int win [2];
        int lat;
        idle(1);
        m_we[0] = 1'b0;  m_addr[0] = 8'h01;  m_wdata[0] = 16'($urandom);
        m_we[1] = 1'b0;  m_addr[1] = 8'h02;  m_wdata[1] = 16'($urandom);
        m_req[0] = 1'b1;
        m_req[1] = 1'b1;
        for (int r = 0; r < rounds; r++) begin
            win[0]  = 1 - last_rr;
            last_rr = win[0];
            win[1]  = 0;
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                check({dut_name[k], " contend_access"}, 64'(snap[k]),
                      64'(pack(0, 0, 1, 0, m_addr[win[k]], m_wdata[win[k]], exp_rdata[k])));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                exp_rdata[k] = ref_mem[m_addr[win[k]]];
                check({dut_name[k], " contend_done"}, 64'(snap[k]),
                      64'(pack(win[k] == 0, win[k] == 1, 0, 0, 8'h0, 16'h0, exp_rdata[k])));
            end
            if (r < rounds - 1) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++)
                    check({dut_name[k], " contend_idle"}, 64'(snap[k]),
                          64'(pack(0, 0, 0, 0, 8'h0, 16'h0, exp_rdata[k])));
            end
        end
        m_req[0] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_fp.m1_ack && lat < 6);
        check("m1_wait_after_m0_drop", 64'(lat), 64'd3);
        last_rr = 1;
        for (int k = 0; k < 2; k++) begin
            exp_rdata[k] = ref_mem[8'h02];
            check({dut_name[k], " m1_served"}, 64'(snap[k]),
                  64'(pack(0, 1, 0, 0, 8'h0, 16'h0, exp_rdata[k])));
        end
        m_req[1] = 1'b0;
        in_done  = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                check({dut_name[k], " reset_state"}, 64'(snap[k]), 64'(pack(0, 0, 0, 0, 8'h0, 16'h0, 16'h0)));
        end
        rst = 1'b0;
        idle(1);

        // Master 0 write then read back.
        txn(0, 1'b1, 8'h10, 16'hBEEF);
        txn(0, 1'b0, 8'h10, 16'($urandom));
        check("rdata_beef", 64'(bus_rr.rdata), 64'h0000_BEEF);

        // Master 1 at the top address.
        idle(1);
        txn(1, 1'b1, 8'hFF, 16'h1234);
        idle(1);
        txn(1, 1'b0, 8'hFF, 16'($urandom));

        // Preload, then both masters contending.
        idle(2);
        txn(0, 1'b1, 8'h01, 16'hAAAA);
        idle(1);
        txn(1, 1'b1, 8'h02, 16'h5555);
        contention(6);

        // Reset while a write sits in ACCESS must not commit it or ack it.
        idle(2);
        txn(0, 1'b1, 8'h20, 16'h0F0F);
        idle(1);
        m_req[0] = 1'b1;  m_we[0] = 1'b1;  m_addr[0] = 8'h20;  m_wdata[0] = 16'hFFFF;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check({dut_name[k], " pre_reset_access"}, 64'(snap[k]), 64'(pack(0, 0, 1, 1, 8'h20, 16'hFFFF, exp_rdata[k])));
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++)
            check({dut_name[k], " async_reset"}, 64'(snap[k]), 64'(pack(0, 0, 0, 0, 8'h0, 16'h0, 16'h0)));
        @(negedge clk);
        m_req[0] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check({dut_name[k], " held_reset"}, 64'(snap[k]), 64'(pack(0, 0, 0, 0, 8'h0, 16'h0, 16'h0)));
        rst = 1'b0;
        model_reset();
        idle(1);
        txn(0, 1'b0, 8'h20, 16'($urandom));
        check("rdata_after_reset", 64'(bus_fp.rdata), 64'h0000_0F0F);

        // Cross-master visibility, with master 0 requesting during master 1's DONE.
        idle(1);
        txn(1, 1'b1, 8'h30, 16'h7777);
        txn(0, 1'b0, 8'h30, 16'($urandom));

        // Random single-master traffic over a small address pool.
        for (int i = 0; i < 40; i++) begin
            txn(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                8'h40 + 8'($urandom_range(7, 0)), 16'($urandom));
            idle(int'($urandom_range(2, 0)));
        end
        contention(3);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
